// File: rtl/load_store_unit_pkg.sv
// Shared datapath types: ALU control/compare codes plus load/store unit states,
// error codes and RV32I load/store funct3 encodings.
package load_store_unit_pkg;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    CompEq, CompNe, CompLt, CompGe, CompLtu, CompGeu
  } alu_comp_t;

  typedef enum logic [1:0] {
    LsuIdle,
    LsuReq,
    LsuDone
  } lsu_state_t;

  typedef enum logic [1:0] {
    LsuErrNone       = 2'd0,
    LsuErrMisaligned = 2'd1,
    LsuErrTimeout    = 2'd2,
    LsuErrIllegal    = 2'd3
  } lsu_err_t;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Sb  = 3'b000;
  localparam logic [2:0] F3Sh  = 3'b001;
  localparam logic [2:0] F3Sw  = 3'b010;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication, byte enables and
// load data extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    mem_wdata = wdata;
    mem_be    = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        mem_wdata = {4{wdata[7:0]}};
        mem_be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        mem_wdata = {2{wdata[15:0]}};
        mem_be    = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3Lb:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3Lh:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3Lbu:   load_data = {24'd0, shifted[7:0]};
      F3Lhu:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store unit: validates the access, runs one req/ready
// bus transaction with an optional timeout and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t     state_q;
  logic           is_store_q;
  logic [2:0]     funct3_q;
  logic [1:0]     addr_lo_q;
  logic [CntW-1:0] cnt_q;

  logic        sel_in;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic [31:0] load_data;
  logic        illegal;
  logic        misaligned;
  logic        timeout_hit;

  // Lane logic sees the live inputs while idle (to set up the request) and the
  // latched access afterwards (to extract load data at the handshake).
  always_comb begin
    sel_in     = (state_q == LsuIdle);
    al_funct3  = sel_in ? funct3 : funct3_q;
    al_addr_lo = sel_in ? addr[1:0] : addr_lo_q;
  end

  lsu_align u_align (
    .funct3    (al_funct3),
    .addr_lo   (al_addr_lo),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_wdata (al_wdata),
    .mem_be    (al_be),
    .load_data (load_data)
  );

  always_comb begin
    illegal     = is_store ? (funct3 > F3Sw) : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned  = (funct3[1:0] == 2'b01 && addr[0]) ||
                  (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LsuIdle;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_code   <= 2'd0;
      rdata      <= 32'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_be     <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        LsuIdle: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            addr_lo_q  <= addr[1:0];
            rdata      <= 32'd0;
            busy       <= 1'b1;
            if (illegal) begin
              state_q  <= LsuDone;
              done     <= 1'b1;
              err_code <= LsuErrIllegal;
            end else if (misaligned) begin
              state_q  <= LsuDone;
              done     <= 1'b1;
              err_code <= LsuErrMisaligned;
            end else begin
              state_q   <= LsuReq;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= al_wdata;
              mem_be    <= al_be;
            end
          end
        end
        LsuReq: begin
          // A ready on the final counted cycle completes the access normally.
          if (mem_ready) begin
            state_q  <= LsuDone;
            done     <= 1'b1;
            err_code <= LsuErrNone;
            rdata    <= is_store_q ? 32'd0 : load_data;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'd0;
          end else if (timeout_hit) begin
            state_q  <= LsuDone;
            done     <= 1'b1;
            err_code <= LsuErrTimeout;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LsuDone: begin
          state_q  <= LsuIdle;
          busy     <= 1'b0;
          err_code <= 2'd0;
        end
        default: state_q <= LsuIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a done-time scoreboard of expected
// error code, load data and completion cycle.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct packed {
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [7:0]  cyc;
  } sb_t;

  sb_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one access from the current (post-edge) cycle, which counts as cycle 0.
  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bus,
                     input int wait_n, input bit poke, input int exp_req_n,
                     input logic [31:0] exp_maddr, input logic [31:0] exp_wdat,
                     input logic [3:0] exp_be, input logic [1:0] exp_err,
                     input logic [31:0] exp_rd, input int exp_done);
    sb_t e;
    int  req_n;
    bit  got;
    sb.push_back('{err: exp_err, rdata: exp_rd, cyc: 8'(exp_done)});
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    req_n    = 0;
    got      = 1'b0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(posedge clk);
      #1;
      start     = 1'b0;
      mem_ready = 1'b0;
      if (mem_req) begin
        req_n++;
        check({tag, "/mem_addr"}, mem_addr, exp_maddr);
        check({tag, "/mem_we"}, {31'd0, mem_we}, {31'd0, st});
        check({tag, "/mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
        if (req_n == 1) check({tag, "/mem_wdata"}, mem_wdata, exp_wdat);
        mem_rdata = bus;
        mem_ready = (req_n == wait_n + 1);
        if (poke && req_n == 1) begin
          start    = 1'b1;
          is_store = 1'b1;
          funct3   = F3Sw;
          addr     = 32'h400;
        end
      end
      if (done) begin
        got = 1'b1;
        e   = sb.pop_front();
        check({tag, "/err"}, {30'd0, err_code}, {30'd0, e.err});
        check({tag, "/rdata"}, rdata, e.rdata);
        check({tag, "/done_cycle"}, c, {24'd0, e.cyc});
      end
    end
    mem_ready = 1'b0;
    check({tag, "/done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "/req_cycles"}, req_n, exp_req_n);
    @(posedge clk);
    #1;
    check({tag, "/idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "/idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "/rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    int n_done;
    int n_req;
    rst       = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", {31'd0, busy}, 32'd0);
    check("rst/done", {31'd0, done}, 32'd0);
    check("rst/err", {30'd0, err_code}, 32'd0);
    check("rst/rdata", rdata, 32'd0);
    check("rst/mem_req", {31'd0, mem_req}, 32'd0);
    check("rst/mem_we", {31'd0, mem_we}, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_wdata", mem_wdata, 32'd0);
    check("rst/mem_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    //   tag    st    f3     addr          wdata         bus           wait poke reqs maddr         mwdata        be       err  rdata         done
    run("lw",   1'b0, F3Lw,  32'h0000_0100, 32'd0,        32'hDEAD_BEEF, 0, 0, 1, 32'h0000_0100, 32'd0,        4'b1111, 2'd0, 32'hDEAD_BEEF, 2);
    run("lb",   1'b0, F3Lb,  32'h0000_0103, 32'd0,        32'h80FF_0000, 0, 0, 1, 32'h0000_0100, 32'd0,        4'b1000, 2'd0, 32'hFFFF_FF80, 2);
    run("lbu",  1'b0, F3Lbu, 32'h0000_0103, 32'd0,        32'h80FF_0000, 0, 0, 1, 32'h0000_0100, 32'd0,        4'b1000, 2'd0, 32'h0000_0080, 2);
    run("lhu",  1'b0, F3Lhu, 32'h0000_0102, 32'd0,        32'h80FF_0000, 0, 0, 1, 32'h0000_0100, 32'd0,        4'b1100, 2'd0, 32'h0000_80FF, 2);
    run("lh",   1'b0, F3Lh,  32'h0000_0102, 32'd0,        32'h80FF_0000, 1, 0, 2, 32'h0000_0100, 32'd0,        4'b1100, 2'd0, 32'hFFFF_80FF, 3);
    run("sb",   1'b1, F3Sb,  32'h0000_0201, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0200, 32'h7878_7878, 4'b0010, 2'd0, 32'd0,         2);
    run("sh",   1'b1, F3Sh,  32'h0000_0202, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0200, 32'h5678_5678, 4'b1100, 2'd0, 32'd0,         2);
    run("sw",   1'b1, F3Sw,  32'h0000_0100, 32'h1234_5678, 32'd0,        2, 0, 3, 32'h0000_0100, 32'h1234_5678, 4'b1111, 2'd0, 32'd0,         4);
    run("lw2",  1'b0, F3Lw,  32'h0000_0104, 32'd0,        32'hCAFE_F00D, 0, 0, 1, 32'h0000_0104, 32'd0,        4'b1111, 2'd0, 32'hCAFE_F00D, 2);
    run("mis_lh", 1'b0, F3Lh, 32'h0000_0101, 32'd0,       32'd0,        0, 0, 0, 32'd0,         32'd0,        4'b0000, 2'd1, 32'd0,         1);
    run("mis_sw", 1'b1, F3Sw, 32'h0000_0102, 32'h1111_2222, 32'd0,      0, 0, 0, 32'd0,         32'd0,        4'b0000, 2'd1, 32'd0,         1);
    run("ill_s3", 1'b1, 3'b011, 32'h0000_0100, 32'd0,     32'd0,        0, 0, 0, 32'd0,         32'd0,        4'b0000, 2'd3, 32'd0,         1);
    run("ill_l6", 1'b0, 3'b110, 32'h0000_0100, 32'd0,     32'd0,        0, 0, 0, 32'd0,         32'd0,        4'b0000, 2'd3, 32'd0,         1);
    run("tmo",  1'b0, F3Lw,  32'h0000_0100, 32'd0,        32'h5555_5555, 100, 0, 4, 32'h0000_0100, 32'd0,      4'b1111, 2'd2, 32'd0,         5);
    run("rdy_last", 1'b0, F3Lw, 32'h0000_0108, 32'd0,     32'h0BAD_CAFE, 3, 0, 4, 32'h0000_0108, 32'd0,        4'b1111, 2'd0, 32'h0BAD_CAFE, 5);
    run("poke", 1'b0, F3Lw,  32'h0000_0100, 32'd0,        32'h1122_3344, 1, 1, 2, 32'h0000_0100, 32'd0,        4'b1111, 2'd0, 32'h1122_3344, 3);

    // The start raised during REQ must not spawn another access.
    n_req = 0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (mem_req) n_req++;
      if (done) n_done++;
    end
    check("poke/no_req", n_req, 0);
    check("poke/no_done", n_done, 0);

    // Asynchronous reset in the middle of a request.
    is_store = 1'b0;
    funct3   = F3Lw;
    addr     = 32'h0000_0300;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("arst/req_up", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst/req_drop", {31'd0, mem_req}, 32'd0);
    check("arst/busy_drop", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done || mem_req) n_done++;
    end
    check("arst/no_done", n_done, 0);
    check("sb/empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multicycle load/store unit that consumes the ALU result as the effective address and rs2v as store data. It performs one RV32I data-memory access over a req/ready bus and returns byte/half/word load data, sign- or zero-extended, for write-back. It sits directly downstream of the ALU and is sequenced by the control FSM via start/done.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles without mem_ready before aborting; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  accept a new access; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- addr  in  32  effective address (ALU_result)
- wdata  in  32  store data (rs2v)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err_code  out  2  valid with done: 0 none, 1 misaligned, 2 timeout, 3 illegal funct3
- rdata  out  32  extended load result; valid from done, held until the next accepted start
- mem_req  out  1  bus request
- mem_we  out  1  write enable
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus acknowledge; ignored outside REQ
- mem_rdata  in  32  bus read word; sampled in the handshake cycle

## Operation
- Outputs are registered. Reset clears the state to IDLE and drives every output to 0.
- States are IDLE, REQ and DONE.
- **IDLE → start=1:** latch is_store, funct3, addr and wdata, then check the access:
  - Illegal: store with funct3 > 010, or load with funct3 in {011, 110, 111}. Go to DONE with err 3.
  - Misaligned: half-word with addr[0] = 1, or word with addr[1:0] ≠ 00. Go to DONE with err 1.
  - Otherwise go to REQ.
  - No bus request is issued on any error.
- **REQ:** mem_req=1, with mem_we, mem_addr, mem_wdata and mem_be stable.
  - When mem_ready=1, the handshake completes. For loads, capture the extracted mem_rdata into rdata. Go to DONE with err 0.
  - If TIMEOUT_CYCLES ≠ 0 and the cycle counter reaches TIMEOUT_CYCLES−1 with mem_ready=0, drop mem_req and go to DONE with err 2. A ready arriving on that same final cycle wins over the timeout.
- **DONE:** done=1 and err_code valid for exactly one cycle, then return to IDLE.
- start while busy is ignored; there is no queueing.
- **Store lanes:**
  - SB: wdata[7:0] replicated ×4, be = 4'b0001 << addr[1:0].
  - SH: wdata[15:0] replicated ×2, be = 4'b0011 << {addr[1], 1'b0}.
  - SW: be = 4'b1111.
- **Load extract:** shift mem_rdata right by addr[1:0]×8, then:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- rdata is set to 0 on stores and on any error.

## Timing
- Successful access: start in cycle 0 → mem_req high in cycle 1.
  - With mem_ready in cycle 1, done is high in cycle 2 and the unit is in IDLE in cycle 3.
  - Latency is 2 + (wait cycles).
- Error access: done is high in cycle 1, and mem_req never rises.
- The timeout counter is 0 in the first REQ cycle. The last REQ cycle is cycle TIMEOUT_CYCLES, and done follows in cycle TIMEOUT_CYCLES+1.
- A new start is accepted in the first IDLE cycle after DONE, so back-to-back throughput is one access per 3 cycles.
- rst asserted mid-REQ drops mem_req immediately (asynchronously). No done is produced for the aborted access.

## Structure
- The shared types package (alongside alu_ctrl_t and alu_comp_t) gains:
  - a lsu_state_t enum;
  - lsu_err_t (NONE, MISALIGNED, TIMEOUT, ILLEGAL);
  - funct3 constants for loads and stores.
- The combinational sub-module lsu_align holds store lane replication, byte enables and load extraction/extension, so it can be unit-tested alone.
- The top module holds the FSM, the latches and the timeout counter.

## Test plan
- LW at addr 0x100 with mem_rdata 0xDEADBEEF and ready in the first REQ cycle → mem_addr 0x100, be 1111, done at cycle 2, rdata 0xDEADBEEF, err 0.
- LB at 0x103 with mem_rdata 0x80FF_0000 → rdata 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
- SB of wdata 0x12345678 at 0x201 → mem_addr 0x200, mem_wdata 0x78787878, be 0010, we 1. SH at 0x202 → be 1100, wdata 0x56785678.
- LH at 0x101, and separately SW at 0x102 → done at cycle 1, err 1, mem_req never high. Store with funct3 011 → err 3.
- TIMEOUT_CYCLES=4 and mem_ready held 0 → mem_req high for cycles 1–4, done at cycle 5, err 2.
- rst asserted during REQ, and start pulsed during REQ → mem_req falls asynchronously on reset, and the second start is ignored.
